// File: rtl/priority_encoder_param.sv
// Parameterized priority encoder: 2**WIDTH request bits to a WIDTH-bit winner index,
// with a zero-latency combinational result and an enable-loaded registered copy.
module priority_encoder_param #(
   parameter int WIDTH     = 3,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [(2**WIDTH)-1:0]   in,
   input  logic                    en,
   output logic [WIDTH-1:0]        result,
   output logic                    valid,
   output logic [WIDTH-1:0]        result_q,
   output logic                    valid_q
);

   localparam int N = 2**WIDTH;

   if (WIDTH < 1) begin : g_width_check
      $fatal(1, "priority_encoder_param: WIDTH must be at least 1 (got %0d)", WIDTH);
   end

   // The scan runs from the lowest-priority end, so the last hit is the winner.
   always_comb begin
      result = '0;
      if (LSB_FIRST) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) result = WIDTH'(i);
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (in[i]) result = WIDTH'(i);
         end
      end
   end

   assign valid = |in;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_q <= '0;
         valid_q  <= 1'b0;
      end else if (en) begin
         result_q <= result;
         valid_q  <= valid;
      end
   end

endmodule

// File: tb/tb_priority_encoder_param.sv
// Bench for priority_encoder_param: WIDTH=3 and WIDTH=1 instances in both priority
// directions, checked against an arithmetic reference model.
module tb_priority_encoder_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [7:0] in8 = '0;
   logic [1:0] in2 = '0;

   logic [2:0] result_a, result_q_a, result_b, result_q_b;
   logic       valid_a, valid_q_a, valid_b, valid_q_b;
   logic [0:0] result_c, result_q_c, result_d, result_q_d;
   logic       valid_c, valid_q_c, valid_d, valid_q_d;

   int n_tests = 0;
   int n_fail  = 0;

   int exp_q_a = 0, exp_q_b = 0, exp_q_c = 0, exp_q_d = 0;
   int exp_v8  = 0, exp_v2  = 0;

   always #5 clk = ~clk;

   priority_encoder_param #(.WIDTH(3), .LSB_FIRST(1'b0)) u_dut_a (
      .clk(clk), .rst(rst), .in(in8), .en(en),
      .result(result_a), .valid(valid_a), .result_q(result_q_a), .valid_q(valid_q_a));

   priority_encoder_param #(.WIDTH(3), .LSB_FIRST(1'b1)) u_dut_b (
      .clk(clk), .rst(rst), .in(in8), .en(en),
      .result(result_b), .valid(valid_b), .result_q(result_q_b), .valid_q(valid_q_b));

   priority_encoder_param #(.WIDTH(1), .LSB_FIRST(1'b0)) u_dut_c (
      .clk(clk), .rst(rst), .in(in2), .en(en),
      .result(result_c), .valid(valid_c), .result_q(result_q_c), .valid_q(valid_q_c));

   priority_encoder_param #(.WIDTH(1), .LSB_FIRST(1'b1)) u_dut_d (
      .clk(clk), .rst(rst), .in(in2), .en(en),
      .result(result_d), .valid(valid_d), .result_q(result_q_d), .valid_q(valid_q_d));

   // Highest set position is floor(log2(v)); lowest is log2 of v with all but its lowest bit cleared.
   function automatic int ref_idx(input int v, input bit lsb_first);
      int x;
      int k;
      if (v == 0) return 0;
      x = lsb_first ? (v & -v) : v;
      k = 0;
      while (x > 1) begin
         x = x / 2;
         k++;
      end
      return k;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_comb(input string tag);
      chk({tag, " result_a"}, int'(result_a), ref_idx(int'(in8), 1'b0));
      chk({tag, " result_b"}, int'(result_b), ref_idx(int'(in8), 1'b1));
      chk({tag, " valid_a"},  int'(valid_a),  int'(in8 != 0));
      chk({tag, " valid_b"},  int'(valid_b),  int'(in8 != 0));
      chk({tag, " result_c"}, int'(result_c), ref_idx(int'(in2), 1'b0));
      chk({tag, " result_d"}, int'(result_d), ref_idx(int'(in2), 1'b1));
      chk({tag, " valid_c"},  int'(valid_c),  int'(in2 != 0));
   endtask

   task automatic check_q(input string tag);
      chk({tag, " result_q_a"}, int'(result_q_a), exp_q_a);
      chk({tag, " result_q_b"}, int'(result_q_b), exp_q_b);
      chk({tag, " valid_q_a"},  int'(valid_q_a),  exp_v8);
      chk({tag, " valid_q_b"},  int'(valid_q_b),  exp_v8);
      chk({tag, " result_q_c"}, int'(result_q_c), exp_q_c);
      chk({tag, " result_q_d"}, int'(result_q_d), exp_q_d);
      chk({tag, " valid_q_d"},  int'(valid_q_d),  exp_v2);
   endtask

   // One rising edge; the model captures the inputs that are stable across it.
   task automatic step();
      bit load;
      int na, nb, nc, nd, nv8, nv2;
      load = rst && en;
      na  = ref_idx(int'(in8), 1'b0);
      nb  = ref_idx(int'(in8), 1'b1);
      nc  = ref_idx(int'(in2), 1'b0);
      nd  = ref_idx(int'(in2), 1'b1);
      nv8 = int'(in8 != 0);
      nv2 = int'(in2 != 0);
      @(posedge clk);
      #1;
      if (!rst) begin
         exp_q_a = 0; exp_q_b = 0; exp_q_c = 0; exp_q_d = 0; exp_v8 = 0; exp_v2 = 0;
      end else if (load) begin
         exp_q_a = na; exp_q_b = nb; exp_q_c = nc; exp_q_d = nd; exp_v8 = nv8; exp_v2 = nv2;
      end
   endtask

   initial begin
      // Reset held with everything active: registered outputs stay clear, comb path tracks.
      rst = 1'b0; en = 1'b1; in8 = 8'hFF; in2 = 2'b11;
      repeat (3) step();
      chk("rst result_q", int'(result_q_a), 0);
      chk("rst valid_q",  int'(valid_q_a), 0);
      chk("rst result",   int'(result_a), 7);
      chk("rst valid",    int'(valid_a), 1);
      check_q("rst");
      check_comb("rst");

      #2 rst = 1'b1;

      for (int k = 0; k < 8; k++) begin
         in8 = 8'(1 << k);
         in2 = 2'(1 << (k % 2));
         #1;
         chk("onehot result_a", int'(result_a), k);
         chk("onehot result_b", int'(result_b), k);
         check_comb("onehot");
         step();
         chk("onehot result_q_a", int'(result_q_a), k);
         check_q("onehot");
      end

      in8 = 8'b0010_1100;
      #1;
      chk("multi msb", int'(result_a), 5);
      chk("multi lsb", int'(result_b), 2);
      chk("multi valid", int'(valid_b), 1);

      in8 = 8'h00; in2 = 2'b00;
      #1;
      chk("empty result", int'(result_a), 0);
      chk("empty valid",  int'(valid_a), 0);
      step();
      chk("empty valid_q",  int'(valid_q_a), 0);
      chk("empty result_q", int'(result_q_a), 0);
      check_q("empty");

      in8 = 8'h40; en = 1'b1;
      step();
      chk("hold load", int'(result_q_a), 6);
      en = 1'b0; in8 = 8'h01; in2 = 2'b01;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("hold result_q", int'(result_q_a), 6);
         chk("hold valid_q",  int'(valid_q_a), 1);
         chk("hold result",   int'(result_a), 0);
         check_q("hold");
      end

      // Asynchronous clear between edges, then release and a normal first load.
      #2 rst = 1'b0;
      #1;
      chk("midrst result_q", int'(result_q_a), 0);
      chk("midrst valid_q",  int'(valid_q_a), 0);
      chk("midrst result",   int'(result_a), 0);
      chk("midrst valid",    int'(valid_a), 1);
      exp_q_a = 0; exp_q_b = 0; exp_q_c = 0; exp_q_d = 0; exp_v8 = 0; exp_v2 = 0;
      check_q("midrst");
      #3 rst = 1'b1;
      en = 1'b1; in8 = 8'h04;
      step();
      chk("post-rst load", int'(result_q_a), 2);
      check_q("post-rst");

      in2 = 2'b11;
      #1;
      chk("w1 msb", int'(result_c), 1);
      chk("w1 lsb", int'(result_d), 0);

      for (int r = 0; r < 300; r++) begin
         case ($urandom_range(0, 3))
            0: in8 = 8'h00;
            1: in8 = 8'(1 << $urandom_range(0, 7));
            default: in8 = 8'($urandom);
         endcase
         in2 = 2'($urandom);
         en  = 1'($urandom_range(0, 3) != 0);
         #1;
         check_comb("rand");
         step();
         check_q("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/priority_encoder_param.md
Name: priority_encoder_param

Overview:
- Parameterized priority encoder.
- Maps a 2**WIDTH-bit one-hot or multi-hot request vector to the WIDTH-bit index of the winning set bit, plus an any-bit-set flag.
- Used by the cache controllers to turn per-line tag-match vectors into a hit-line index.
- Provides a combinational result for same-cycle use, and a registered copy for pipelined use.

Parameters:
- WIDTH, 3: width of the result index. Input width is N = 2**WIDTH. WIDTH < 1 triggers elaboration-time $fatal.
- LSB_FIRST, 0: priority direction. 0 = highest set index wins. 1 = lowest set index wins.

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in  input  N  request vector; bit i set means candidate i.
- en  input  1  load enable for the registered outputs.
- result  output  WIDTH  combinational index of the winning bit.
- valid  output  1  combinational OR-reduction of in.
- result_q  output  WIDTH  registered copy of result.
- valid_q  output  1  registered copy of valid.

Behaviour:
- Combinational path, zero latency:
  - With LSB_FIRST=0, result is the largest i with in[i]=1.
  - With LSB_FIRST=1, result is the smallest such i.
  - valid = |in.
- in == 0: result = 0 and valid = 0. Consumers must qualify result with valid.
- Exactly one bit set: result equals that bit's index, irrespective of LSB_FIRST.
- Implementation: loop or generate based, fully parameterized; no hard-coded case tables. No latches; outputs are defined for every input.
- Registered path:
  - While rst = 0, result_q = 0 and valid_q = 0, asynchronously. This holds regardless of clk, en or in.
  - After reset release, on each rising edge with en = 1: result_q <= result, valid_q <= valid. Latency is 1 cycle.
  - On a rising edge with en = 0, result_q and valid_q hold their previous values.
- Reset asserted mid-operation clears the registered outputs immediately. The combinational outputs keep tracking in, because they do not depend on reset.
- The first rising edge after reset release with en = 1 loads normally. No extra flush cycle.
- Width rule: index arithmetic is performed in WIDTH bits. N-1 is the maximum result and always fits.
- No X propagation when in is fully known.

Test Plan:
- Reset: drive rst = 0 with in = 8'hFF and en = 1, toggle clk -> result_q = 0, valid_q = 0. Combinational result = 7, valid = 1 (WIDTH=3, LSB_FIRST=0).
- One-hot sweep: WIDTH=3, in = 1<<k for k = 0..7 -> result = k and valid = 1 in the same cycle; result_q = k one cycle later with en = 1.
- Multi-hot priority: in = 8'b0010_1100 -> result = 5 with LSB_FIRST=0, and result = 2 with LSB_FIRST=1; valid = 1 in both cases.
- Empty input: in = 0 -> result = 0 and valid = 0; after a clock with en = 1, valid_q = 0 and result_q = 0.
- Enable hold: load in = 8'h40 (result_q = 6), then set en = 0 and in = 8'h01 for 3 cycles -> result_q stays 6, valid_q stays 1, combinational result = 0.
- Mid-operation reset and WIDTH=1 corner: assert rst = 0 between edges while result_q = 6 -> result_q goes to 0 at once, before the next edge. WIDTH=1 with in = 2'b11 -> result = 1 when LSB_FIRST=0, result = 0 when LSB_FIRST=1.
